// File: rtl/mult_div.sv
// rtl/mult_div.sv - multicycle signed multiply (radix-2 Booth) and divide (restoring) with HI/LO result registers
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [64:0] acc;
  logic [31:0] opnd;
  logic [4:0]  count;
  logic        iter_done;
  logic        a_neg, b_neg;

  logic [31:0] a_mag, b_mag;
  logic [32:0] booth_sum;
  logic [64:0] acc_mult;
  logic [32:0] div_shift, div_diff;
  logic [64:0] acc_div;
  logic [31:0] quo_signed, rem_signed;

  // Multiply layout: acc[64:33] upper partial, acc[32:1] multiplier, acc[0] Booth bit.
  // Divide layout:   acc[63:32] remainder, acc[31:0] dividend shifting into quotient.
  always_comb begin
    a_mag = a[31] ? (~a + 32'd1) : a;
    b_mag = b[31] ? (~b + 32'd1) : b;

    // 33-bit add keeps the -2^31 multiplicand from overflowing the partial
    booth_sum = {acc[64], acc[64:33]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[64], acc[64:33]} + {opnd[31], opnd};
      2'b10:   booth_sum = {acc[64], acc[64:33]} - {opnd[31], opnd};
      default: booth_sum = {acc[64], acc[64:33]};
    endcase
    acc_mult = {booth_sum, acc[32:1]};

    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opnd};
    if (!div_diff[32])
      acc_div = {1'b0, div_diff[31:0], acc[30:0], 1'b1};
    else
      acc_div = {1'b0, div_shift[31:0], acc[30:0], 1'b0};

    quo_signed = (a_neg ^ b_neg) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_signed = a_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mult)     state_nxt = MULT;
        else if (start_div) state_nxt = (b == 32'd0) ? DONE : DIV;
      end
      MULT, DIV: if (iter_done) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      opnd      <= '0;
      count     <= '0;
      iter_done <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      busy <= (state_nxt == MULT) || (state_nxt == DIV);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            count     <= '0;
            iter_done <= 1'b0;
            div_zero  <= !start_mult && (b == 32'd0);
            if (start_mult) begin
              acc  <= {32'd0, a, 1'b0};
              opnd <= b;
            end else begin
              acc   <= {33'd0, a_mag};
              opnd  <= b_mag;
              a_neg <= a[31];
              b_neg <= b[31];
            end
          end
        end
        MULT, DIV: begin
          if (iter_done) begin
            if (state == MULT) begin
              hi <= acc[64:33];
              lo <= acc[32:1];
            end else begin
              hi <= rem_signed;
              lo <= quo_signed;
            end
          end else begin
            acc <= (state == MULT) ? acc_mult : acc_div;
            if (count == 5'd31) iter_done <= 1'b1;
            else                count     <= count + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
